// File: rtl/enter_key_controller_if.sv
// Processor-side register interface of the Enter-key controller.
// dmem drives the access strobes and reads back the capture state.
interface enter_key_controller_if #(
    parameter int SW_WIDTH = 8
);
    logic                rd_strobe;
    logic                ovr_clr;
    logic [SW_WIDTH-1:0] data_out;
    logic                valid;
    logic                overrun;
    logic                enter_pulse;

    modport master (
        output rd_strobe, ovr_clr,
        input  data_out, valid, overrun, enter_pulse
    );

    modport slave (
        input  rd_strobe, ovr_clr,
        output data_out, valid, overrun, enter_pulse
    );
endinterface

// File: rtl/enter_key_controller.sv
// Debounced Enter-key capture of the switch bank, with a sticky valid flag
// for processor polling and overrun detection when data is overwritten unread.
module enter_key_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        nEnter,
    input  logic [SW_WIDTH-1:0]         switches,
    enter_key_controller_if.slave       bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    logic [1:0]          n_sync;
    logic [SW_WIDTH-1:0] sw_sync0, sw_sync1;
    logic                press;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                capture;

    logic [SW_WIDTH-1:0] data_q;
    logic                valid_q, overrun_q, pulse_q;

    // Button syncs to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            n_sync   <= 2'b11;
            sw_sync0 <= '0;
            sw_sync1 <= '0;
        end else begin
            n_sync   <= {n_sync[0], nEnter};
            sw_sync0 <= switches;
            sw_sync1 <= sw_sync0;
        end
    end

    assign press = ~n_sync[1];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            PRESS_WAIT: begin
                if (!press) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HELD: begin
                if (!press) begin
                    state_d = REL_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            REL_WAIT: begin
                if (press) begin
                    state_d = HELD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture outranks a same-edge read; an overrun set outranks a same-edge clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= capture;
            if (capture) begin
                data_q  <= sw_sync1;
                valid_q <= 1'b1;
            end else if (bus.rd_strobe) begin
                valid_q <= 1'b0;
            end
            if (capture && valid_q && !bus.rd_strobe)
                overrun_q <= 1'b1;
            else if (bus.ovr_clr)
                overrun_q <= 1'b0;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.valid       = valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.enter_pulse = pulse_q;
endmodule

// File: tb/tb_enter_key_controller.sv
// Directed bench for enter_key_controller with a 4-cycle debounce window.
module tb_enter_key_controller;
    localparam int DB = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic          nEnter;
    logic [SW-1:0] switches;
    int            total = 0;
    int            bad   = 0;
    logic          saw_pulse;

    enter_key_controller_if #(.SW_WIDTH(SW)) bus ();

    enter_key_controller #(.DEBOUNCE_CYCLES(DB), .SW_WIDTH(SW)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .nEnter   (nEnter),
        .switches (switches),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full press/release with no reads; capture lands 7 edges after the press.
    task automatic press_release(input logic [SW-1:0] sw);
        switches = sw;
        cyc(3);
        nEnter = 1'b0;
        cyc(10);
        nEnter = 1'b1;
        cyc(10);
    endtask

    initial begin
        nreset   = 1'b0;
        nEnter   = 1'b1;
        switches = '0;
        bus.rd_strobe = 1'b0;
        bus.ovr_clr   = 1'b0;
        #3;
        chk("rst_data",    32'(bus.data_out), 0);
        chk("rst_valid",   32'(bus.valid), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_pulse",   32'(bus.enter_pulse), 0);
        cyc(1);
        nreset = 1'b1;

        // Clean press: pulse exactly on edge 7, valid from edge 7 on, nothing more while held
        switches = 8'hA5;
        cyc(3);
        nEnter = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk($sformatf("press_pulse_e%0d", k), 32'(bus.enter_pulse), (k == 7) ? 1 : 0);
            chk($sformatf("press_valid_e%0d", k), 32'(bus.valid), (k >= 7) ? 1 : 0);
        end
        chk("press_data", 32'(bus.data_out), 32'hA5);
        chk("press_ovr",  32'(bus.overrun), 0);
        nEnter = 1'b1;
        cyc(10);

        // Read and clear, then redundant reads
        bus.rd_strobe = 1'b1;
        cyc(1);
        bus.rd_strobe = 1'b0;
        chk("rd_valid", 32'(bus.valid), 0);
        chk("rd_data",  32'(bus.data_out), 32'hA5);
        bus.rd_strobe = 1'b1;
        cyc(2);
        bus.rd_strobe = 1'b0;
        cyc(1);
        chk("rd2_valid", 32'(bus.valid), 0);
        chk("rd2_data",  32'(bus.data_out), 32'hA5);
        chk("rd2_ovr",   32'(bus.overrun), 0);

        // Bounce reject: low 3, high 2, low 2, high 10
        switches = 8'h5A;
        saw_pulse = 1'b0;
        nEnter = 1'b0; cyc(3);
        nEnter = 1'b1; cyc(2);
        nEnter = 1'b0; cyc(2);
        nEnter = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.enter_pulse) saw_pulse = 1'b1;
            cyc(1);
        end
        chk("bounce_pulse", 32'(saw_pulse), 0);
        chk("bounce_valid", 32'(bus.valid), 0);
        chk("bounce_data",  32'(bus.data_out), 32'hA5);

        // Overrun: two captures without a read
        press_release(8'h11);
        chk("ov1_data",  32'(bus.data_out), 32'h11);
        chk("ov1_valid", 32'(bus.valid), 1);
        chk("ov1_ovr",   32'(bus.overrun), 0);
        press_release(8'h22);
        chk("ov2_data",  32'(bus.data_out), 32'h22);
        chk("ov2_valid", 32'(bus.valid), 1);
        chk("ov2_ovr",   32'(bus.overrun), 1);
        bus.ovr_clr = 1'b1;
        cyc(1);
        bus.ovr_clr = 1'b0;
        chk("clr_ovr",   32'(bus.overrun), 0);
        chk("clr_valid", 32'(bus.valid), 1);
        chk("clr_data",  32'(bus.data_out), 32'h22);

        // rd_strobe on the capture edge: capture wins, no overrun
        switches = 8'h33;
        cyc(3);
        nEnter = 1'b0;
        cyc(6);
        bus.rd_strobe = 1'b1;
        cyc(1);
        bus.rd_strobe = 1'b0;
        chk("sim_rd_pulse", 32'(bus.enter_pulse), 1);
        chk("sim_rd_valid", 32'(bus.valid), 1);
        chk("sim_rd_ovr",   32'(bus.overrun), 0);
        chk("sim_rd_data",  32'(bus.data_out), 32'h33);
        cyc(1);
        chk("pulse_single", 32'(bus.enter_pulse), 0);
        nEnter = 1'b1;
        cyc(10);

        // ovr_clr on the overrun-set edge: set wins
        switches = 8'h44;
        cyc(3);
        nEnter = 1'b0;
        cyc(6);
        bus.ovr_clr = 1'b1;
        cyc(1);
        bus.ovr_clr = 1'b0;
        chk("sim_clr_ovr",  32'(bus.overrun), 1);
        chk("sim_clr_data", 32'(bus.data_out), 32'h44);
        nEnter = 1'b1;
        cyc(10);

        // Async reset mid-PRESS_WAIT, then a held button debounces from IDLE
        switches = 8'h5C;
        cyc(3);
        nEnter = 1'b0;
        cyc(4);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_data",  32'(bus.data_out), 0);
        chk("arst_valid", 32'(bus.valid), 0);
        chk("arst_ovr",   32'(bus.overrun), 0);
        chk("arst_pulse", 32'(bus.enter_pulse), 0);
        cyc(2);
        nreset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            chk($sformatf("arst_pulse_e%0d", k), 32'(bus.enter_pulse), (k == 7) ? 1 : 0);
        end
        chk("arst_cap_data",  32'(bus.data_out), 32'h5C);
        chk("arst_cap_valid", 32'(bus.valid), 1);
        chk("arst_cap_ovr",   32'(bus.overrun), 0);
        nEnter = 1'b1;
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
